rvvi_trace_sequencer: RTL

Sits between the core's RVFI retirement signals and the RVVI trace consumer (ISS comparator / tracer), which may back-pressure. Buffers retirement records in an in-order FIFO and releases them one per handshake. Checks that retirement order numbers are contiguous. Requests a core stall before the buffer can overflow, and halts the stream on error when configured to.

---
 rtl/rvvi_trace_sequencer_pkg.sv | 39 +++
 rtl/rvvi_trace_sequencer_if.sv | 46 ++++
 rtl/rvvi_trace_sequencer_fifo.sv | 52 +++++
 rtl/rvvi_trace_sequencer.sv | 106 ++++++++++
 4 files changed

// File: rtl/rvvi_trace_sequencer_pkg.sv
// Shared types for the RVVI trace sequencer: the buffered retirement record and the sequencer FSM state.
package rvvi_trace_sequencer_pkg;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        trap;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        rd_wb;
  } trace_rec_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_e;

  // x0 writes are architecturally invisible, so the record carries no writeback and zero data.
  function automatic trace_rec_t make_rec(
    input logic [63:0] order,
    input logic [31:0] pc,
    input logic [31:0] insn,
    input logic        trap,
    input logic [4:0]  rd_addr,
    input logic [31:0] rd_wdata
  );
    trace_rec_t r;
    r.order    = order;
    r.pc       = pc;
    r.insn     = insn;
    r.trap     = trap;
    r.rd_addr  = rd_addr;
    r.rd_wb    = (rd_addr != 5'd0);
    r.rd_wdata = r.rd_wb ? rd_wdata : 32'd0;
    return r;
  endfunction

endpackage

// File: rtl/rvvi_trace_sequencer_if.sv
// Retirement-in / trace-out bundle of the sequencer; slave is the sequencer side, master the core/consumer side.
interface rvvi_trace_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          flush_i;
  logic          ret_valid_i;
  logic [63:0]   ret_order_i;
  logic [31:0]   ret_pc_i;
  logic [31:0]   ret_insn_i;
  logic          ret_trap_i;
  logic [4:0]    ret_rd_addr_i;
  logic [31:0]   ret_rd_wdata_i;
  logic          stall_req_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [63:0]   out_order_o;
  logic [31:0]   out_pc_o;
  logic [31:0]   out_insn_o;
  logic          out_trap_o;
  logic [4:0]    out_rd_addr_o;
  logic [31:0]   out_rd_wdata_o;
  logic          out_rd_wb_o;
  logic [CW-1:0] count_o;
  logic          order_err_o;
  logic          overflow_o;
  logic          halted_o;

  modport slave (
    input  flush_i, ret_valid_i, ret_order_i, ret_pc_i, ret_insn_i, ret_trap_i,
           ret_rd_addr_i, ret_rd_wdata_i, out_ready_i,
    output stall_req_o, out_valid_o, out_order_o, out_pc_o, out_insn_o, out_trap_o,
           out_rd_addr_o, out_rd_wdata_o, out_rd_wb_o, count_o, order_err_o,
           overflow_o, halted_o
  );

  modport master (
    output flush_i, ret_valid_i, ret_order_i, ret_pc_i, ret_insn_i, ret_trap_i,
           ret_rd_addr_i, ret_rd_wdata_i, out_ready_i,
    input  stall_req_o, out_valid_o, out_order_o, out_pc_o, out_insn_o, out_trap_o,
           out_rd_addr_o, out_rd_wdata_o, out_rd_wb_o, count_o, order_err_o,
           overflow_o, halted_o
  );

endinterface

// File: rtl/rvvi_trace_sequencer_fifo.sv
// In-order DEPTH x trace_rec_t FIFO with registered storage and fall-through head.
// Latency: a push at edge N is visible on dout after edge N (one cycle through an empty FIFO).
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module trace_fifo
  import rvvi_trace_sequencer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  trace_rec_t               din,
  output trace_rec_t               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  trace_rec_t  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rvvi_trace_sequencer.sv
// Buffers RVFI retirements for an RVVI consumer, checks order contiguity, flags overflow, halts on error.
// Latency: one cycle from retirement to out_valid_o through an empty buffer.
// Backpressure: consumer stalls via out_ready_i; core is asked to stop via stall_req_o (almost-full or halted).
module rvvi_trace_sequencer
  import rvvi_trace_sequencer_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AFULL_MARGIN = 2,
  parameter bit HALT_ON_ERR  = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  rvvi_trace_sequencer_if.slave  bus
);

  localparam int            CW        = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] AFULL_LVL = CW'(DEPTH - AFULL_MARGIN);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

  seq_state_e    state;
  logic [63:0]   exp_order;
  logic          order_err;
  logic          overflow;
  logic          stall;
  trace_rec_t    in_rec;
  trace_rec_t    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          run;
  logic          push;
  logic          pop;
  logic          drop;
  logic          order_bad;
  logic          err_evt;

  // Flush wins over both handshakes; HALTED blocks pushes but keeps draining.
  assign run       = (state == RUN);
  assign pop       = !empty && bus.out_ready_i && !bus.flush_i;
  assign push      = bus.ret_valid_i && run && !bus.flush_i && (!full || pop);
  assign drop      = bus.ret_valid_i && run && !bus.flush_i && full && !pop;
  assign order_bad = push && (bus.ret_order_i != exp_order);
  assign err_evt   = order_bad || drop;

  assign in_rec = make_rec(bus.ret_order_i, bus.ret_pc_i, bus.ret_insn_i, bus.ret_trap_i,
                           bus.ret_rd_addr_i, bus.ret_rd_wdata_i);

  always_comb begin
    count_nxt = count;
    if (bus.flush_i)         count_nxt = '0;
    else if (push && !pop)   count_nxt = count + CNT_ONE;
    else if (pop && !push)   count_nxt = count - CNT_ONE;
  end

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .clr   (bus.flush_i),
    .push  (push),
    .pop   (pop),
    .din   (in_rec),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Expected order always resyncs to the last accepted order + 1, so one gap reports once.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= RUN;
      exp_order <= '0;
      order_err <= 1'b0;
      overflow  <= 1'b0;
      stall     <= 1'b0;
    end else if (bus.flush_i) begin
      state     <= RUN;
      exp_order <= '0;
      stall     <= 1'b0;
    end else begin
      if (push)      exp_order <= bus.ret_order_i + 64'd1;
      if (order_bad) order_err <= 1'b1;
      if (drop)      overflow  <= 1'b1;
      if (HALT_ON_ERR && err_evt) state <= HALTED;
      stall <= (HALT_ON_ERR && err_evt) || !run || (count_nxt >= AFULL_LVL);
    end
  end

  assign bus.stall_req_o    = stall;
  assign bus.out_valid_o    = !empty;
  assign bus.out_order_o    = head.order;
  assign bus.out_pc_o       = head.pc;
  assign bus.out_insn_o     = head.insn;
  assign bus.out_trap_o     = head.trap;
  assign bus.out_rd_addr_o  = head.rd_addr;
  assign bus.out_rd_wdata_o = head.rd_wdata;
  assign bus.out_rd_wb_o    = head.rd_wb;
  assign bus.count_o        = count;
  assign bus.order_err_o    = order_err;
  assign bus.overflow_o     = overflow;
  assign bus.halted_o       = (state == HALTED);

endmodule
